branch_resolve_ctrl: RTL
========================

// Module: branch_resolve_ctrl
// PURPOSE
//  Sequencer around the branch condition evaluator. Accepts one branch op at a time from decode
//  (valid/ready), registers operands, evaluates the condition, computes the target and drives the
//  fetch redirect handshake. Sits between decode/regfile read and fetch; keeps taken/total stats.
// PARAMETERS
//  DW     32  operand width (br_a, br_b)
//  AW     32  PC width
//  CNT_W  16  width of statistics counters (saturating)
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      reset, asynchronous, active-high
//  br_valid     in   1      branch op offered by decode
//  br_ready     out  1      controller can accept (IDLE only)
//  br_bf        in   4      branch function code
//  br_a         in   DW     operand a (rs)
//  br_b         in   DW     operand b (rt)
//  br_pc        in   AW     PC of branch instruction
//  br_off       in   16     signed word offset
//  flush_i      in   1      pipeline flush (exception); aborts current op
//  redir_valid  out  1      redirect request to fetch
//  redir_ready  in   1      fetch accepts redirect
//  redir_pc     out  AW     target = br_pc + 4 + (sext(br_off) << 2), mod 2^AW
//  annul        out  1      1-cycle pulse: kill delay slot (likely branch not taken)
//  done         out  1      1-cycle pulse: op resolved (taken after redirect accepted, or not taken)
//  taken        out  1      outcome, valid while done=1
//  stat_total   out  CNT_W  resolved branches, saturates at all-ones
//  stat_taken   out  CNT_W  taken branches, saturates at all-ones
// BEHAVIOUR
//  Reset: state IDLE; br_ready=1 (comb from state); redir_valid=0, redir_pc=0, annul=0, done=0,
//   taken=0, stats=0, operand regs=0.
//  Conditions (signed compare): 0010 a<0; 0011 a>=0; 100x a==b; 101x a!=b; 110x a<=b; 111x a>b;
//   other codes: never taken. bf[3]=1 & bf[0]=1 => "likely" variant. Codes 0010/0011 never likely.
//  FSM IDLE -> EVAL -> RESOLVE -> (REDIRECT) -> IDLE:
//   IDLE: br_ready=1; on br_valid&!flush_i capture bf,a,b,pc,off -> EVAL.
//   EVAL: compute cond + target into regs -> RESOLVE.
//   RESOLVE: taken -> REDIRECT (redir_valid=1 from next cycle). Not taken -> done=1, taken=0,
//    annul=1 iff likely, stat_total++ -> IDLE.
//   REDIRECT: redir_valid, redir_pc held stable until redir_ready; on handshake: done=1, taken=1,
//    stat_total++, stat_taken++ -> IDLE (redir_valid drops next cycle).
//  Latency: accept at cycle 0; not-taken done at cycle 2; redir_valid first high cycle 3.
//  flush_i: any state -> IDLE next cycle; clears redir_valid; no done/annul; stats unchanged.
//   flush_i wins over br_valid and over a same-cycle redir_ready (no stat update).
//  No back-to-back accept: br_ready low from EVAL through final cycle; next accept earliest in IDLE.
//  Stats saturate: at all-ones, increments are ignored (no wrap).
//  Target arithmetic wraps mod 2^AW; off sign-extended to AW before shift.
//  Async rst mid-op: immediate return to reset values, in-flight op discarded.
// STRUCTURE
//  Package branch_pkg: bf code localparams (BF_LTZ, BF_GEZ, BF_EQ, BF_NE, BF_LE, BF_GT), state
//   enum/encodings, is_likely(bf) function.
//  Sub-module branch_cond_eval (combinational: bf,a,b -> taken, likely), instantiated in EVAL path.
//  Top: FSM, operand/target regs, redirect handshake, saturating counters.
// TESTING
//  1. bf=1000, a=5, b=5, pc=0x100, off=0x0004, redir_ready=1 -> redir_valid @c3, redir_pc=0x114,
//     done=1 taken=1, stat_taken=1.
//  2. bf=0010, a=0xFFFFFFFF (-1) -> taken; bf=0010, a=1 -> done@c2, taken=0, annul=0.
//  3. bf=1011, a=b=7 (likely NE, not taken) -> annul=1 & done=1 same cycle, no redir_valid.
//  4. bf=1110, a=3, b=2, redir_ready low 5 cycles -> redir_valid/redir_pc stable, done once on accept.
//  5. flush_i during REDIRECT with redir_ready=1 -> IDLE, no done, stats unchanged; br_valid+flush_i
//     in IDLE -> not accepted.
//  6. CNT_W=2: 5 taken branches -> stat_taken=3 (saturated); bf=0101 -> not taken;
//     pc=0xFFFFFFFC, off=0 -> redir_pc=0x0.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve controller: function codes,
// FSM state encoding and the "likely" decode helper.
package branch_pkg;

   // Branch function codes (low bit of the 1xxx codes selects the likely variant)
   localparam logic [3:0] BF_LTZ = 4'b0010;
   localparam logic [3:0] BF_GEZ = 4'b0011;
   localparam logic [3:0] BF_EQ  = 4'b1000;
   localparam logic [3:0] BF_NE  = 4'b1010;
   localparam logic [3:0] BF_LE  = 4'b1100;
   localparam logic [3:0] BF_GT  = 4'b1110;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_EVAL     = 2'd1,
      ST_RESOLVE  = 2'd2,
      ST_REDIRECT = 2'd3
   } br_state_t;

   // Likely variants are the two-operand codes with bf[0] set; 0010/0011 have bf[3]=0
   function automatic logic is_likely(input logic [3:0] bf);
      return bf[3] & bf[0];
   endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator: signed compares selected by bf.
module branch_cond_eval
   import branch_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic [3:0]    bf,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic          taken,
   output logic          likely
);

   logic signed [DW-1:0] sa;
   logic signed [DW-1:0] sb;

   assign sa = a;
   assign sb = b;

   // Decode the function code; undefined codes are never taken
   always_comb begin
      taken  = 1'b0;
      likely = is_likely(bf);
      if (bf == BF_LTZ) begin
         taken = a[DW-1];
      end else if (bf == BF_GEZ) begin
         taken = ~a[DW-1];
      end else if (bf[3:1] == BF_EQ[3:1]) begin
         taken = (a == b);
      end else if (bf[3:1] == BF_NE[3:1]) begin
         taken = (a != b);
      end else if (bf[3:1] == BF_LE[3:1]) begin
         taken = (sa <= sb);
      end else if (bf[3:1] == BF_GT[3:1]) begin
         taken = (sa > sb);
      end
   end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolve sequencer: accepts one branch op from decode, evaluates it,
// drives the fetch redirect and keeps saturating taken/total statistics.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The sender holds valid and its payload stable until that edge;
// ready never depends on the same-cycle valid. br_valid/br_ready transfers
// from decode into this block, redir_valid/redir_ready from this block to fetch.
module branch_resolve_ctrl
   import branch_pkg::*;
#(
   parameter int DW    = 32,
   parameter int AW    = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             br_valid,
   output logic             br_ready,
   input  logic [3:0]       br_bf,
   input  logic [DW-1:0]    br_a,
   input  logic [DW-1:0]    br_b,
   input  logic [AW-1:0]    br_pc,
   input  logic [15:0]      br_off,
   input  logic             flush_i,
   output logic             redir_valid,
   input  logic             redir_ready,
   output logic [AW-1:0]    redir_pc,
   output logic             annul,
   output logic             done,
   output logic             taken,
   output logic [CNT_W-1:0] stat_total,
   output logic [CNT_W-1:0] stat_taken,
   output logic [1:0]       dbg_state
);

   br_state_t         state;
   br_state_t         state_nx;

   logic [3:0]        bf_r;
   logic [DW-1:0]     a_r;
   logic [DW-1:0]     b_r;
   logic [AW-1:0]     pc_r;
   logic [15:0]       off_r;
   logic              taken_r;
   logic              likely_r;
   logic [AW-1:0]     target_r;

   logic              cond_taken;
   logic              cond_likely;
   logic [AW-1:0]     off_sext;
   logic [AW-1:0]     target_nx;
   logic              accept;
   logic              resolve_nt;
   logic              redir_fire;

   branch_cond_eval #(.DW(DW)) u_cond (
      .bf     (bf_r),
      .a      (a_r),
      .b      (b_r),
      .taken  (cond_taken),
      .likely (cond_likely)
   );

   // Word offset is sign-extended to the PC width before the shift; sum wraps mod 2^AW
   assign off_sext  = {{(AW-16){off_r[15]}}, off_r};
   assign target_nx = pc_r + AW'(4) + (off_sext << 2);

   // Flush overrides every event that would otherwise complete in this cycle
   assign accept     = (state == ST_IDLE) & br_valid & ~flush_i;
   assign resolve_nt = (state == ST_RESOLVE) & ~taken_r & ~flush_i;
   assign redir_fire = (state == ST_REDIRECT) & redir_ready & ~flush_i;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // Next-state logic; flush returns to IDLE from anywhere
   always_comb begin
      state_nx = state;
      if (flush_i) begin
         state_nx = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:     if (br_valid) state_nx = ST_EVAL;
            ST_EVAL:     state_nx = ST_RESOLVE;
            ST_RESOLVE:  state_nx = taken_r ? ST_REDIRECT : ST_IDLE;
            ST_REDIRECT: if (redir_ready) state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
         endcase
      end
   end

   // Outputs decoded from state and the registered outcome
   always_comb begin
      br_ready    = (state == ST_IDLE);
      redir_valid = (state == ST_REDIRECT);
      redir_pc    = target_r;
      done        = resolve_nt | redir_fire;
      taken       = redir_fire;
      annul       = resolve_nt & likely_r;
      dbg_state   = state;
   end

   // Operand capture on accept, condition and target capture in EVAL
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bf_r     <= '0;
         a_r      <= '0;
         b_r      <= '0;
         pc_r     <= '0;
         off_r    <= '0;
         taken_r  <= 1'b0;
         likely_r <= 1'b0;
         target_r <= '0;
      end else begin
         if (accept) begin
            bf_r  <= br_bf;
            a_r   <= br_a;
            b_r   <= br_b;
            pc_r  <= br_pc;
            off_r <= br_off;
         end
         if (state == ST_EVAL && !flush_i) begin
            taken_r  <= cond_taken;
            likely_r <= cond_likely;
            target_r <= target_nx;
         end
      end
   end

   // Saturating statistics, bumped only when an op completes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_total <= '0;
         stat_taken <= '0;
      end else begin
         if (done && stat_total != '1) stat_total <= stat_total + CNT_W'(1);
         if (redir_fire && stat_taken != '1) stat_taken <= stat_taken + CNT_W'(1);
      end
   end

endmodule
